// File: rtl/csa_sum_divider_if.sv
// Handshake bundle between the CSA sum producer, the restoring divider and the result consumer.
// The master side issues dividend/divisor and accepts results; the slave side is the divider.
interface csa_sum_divider_if #(
   parameter int W  = 16,
   parameter int DW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  dividend;
   logic [DW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  quotient;
   logic [DW-1:0] remainder;
   logic          div_by_zero;
   logic          busy;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero, busy
   );
endinterface

// File: rtl/csa_sum_divider.sv
// Restoring divider producing one quotient bit per clock from the CSA sum.
// Optional macro CSA_DIV_ROUND_NEAREST_EN rounds the quotient to nearest on completion.
module csa_sum_divider #(
   parameter int W  = 16,
   parameter int DW = 8
) (
   input logic               clk,
   input logic               rst,
   csa_sum_divider_if.slave  bus
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  dsr;
   logic [DW-1:0] dvr;
   logic [DW:0]   rem;
   logic [CW-1:0] cnt;

   logic [DW+1:0] rem_sh;
   logic [DW+1:0] trial;
   logic          fits;
   logic [DW:0]   rem_next;
   logic [W-1:0]  q_next;
   logic [W-1:0]  q_final;

   // The top bit of the widened trial is the borrow; the partial remainder stays below
   // the divisor, so the shifted value never reaches that bit and it is a true sign.
   always_comb begin
      rem_sh   = {rem, dsr[W-1]};
      trial    = rem_sh - {2'b00, dvr};
      fits     = ~trial[DW+1];
      rem_next = fits ? trial[DW:0] : rem_sh[DW:0];
      q_next   = {dsr[W-2:0], fits};
`ifdef CSA_DIV_ROUND_NEAREST_EN
      q_final  = q_next;
      if (({rem_next, 1'b0} >= {2'b00, dvr}) && (q_next != {W{1'b1}}))
         q_final = q_next + W'(1);
`else
      q_final  = q_next;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         dsr             <= '0;
         dvr             <= '0;
         rem             <= '0;
         cnt             <= '0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
         bus.out_valid   <= 1'b0;
         bus.busy        <= 1'b0;
         bus.in_ready    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  bus.busy     <= 1'b1;
                  bus.in_ready <= 1'b0;
                  if (bus.divisor == '0) begin
                     bus.quotient    <= '1;
                     bus.remainder   <= bus.dividend[DW-1:0];
                     bus.div_by_zero <= 1'b1;
                     bus.out_valid   <= 1'b1;
                     state           <= DONE;
                  end else begin
                     dsr   <= bus.dividend;
                     dvr   <= bus.divisor;
                     rem   <= '0;
                     cnt   <= '0;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               dsr <= q_next;
               rem <= rem_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) begin
                  bus.quotient    <= q_final;
                  bus.remainder   <= rem_next[DW-1:0];
                  bus.div_by_zero <= 1'b0;
                  bus.out_valid   <= 1'b1;
                  state           <= DONE;
               end
            end
            DONE: begin
               // Result registers are left untouched on drain; only the valid flag clears.
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.busy      <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_sum_divider.sv
// Scoreboard bench for csa_sum_divider: directed vectors push expected results,
// an independent monitor pops and compares whenever out_valid rises.
module tb_csa_sum_divider;

   localparam int W  = 16;
   localparam int DW = 8;
`ifdef CSA_DIV_ROUND_NEAREST_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   typedef struct {
      logic [W-1:0]  q;
      logic [DW-1:0] r;
      logic          dbz;
      int            lat;
      int            acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   exp_t sb[$];
   exp_t cur;
   bit   have_cur = 1'b0;
   logic prev_ov = 1'b0;

   csa_sum_divider_if #(.W(W), .DW(DW)) bus ();
   csa_sum_divider #(.W(W), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Waits for in_ready, presents one request for a single cycle and optionally
   // records the hand-computed result in the scoreboard.
   task automatic applyStimulus(input logic [W-1:0] dd, input logic [DW-1:0] dv,
                                input logic [W-1:0] eq, input logic [DW-1:0] er,
                                input logic edbz, input bit track);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         fails++;
         $display("[TB] FAIL accept_timeout: in_ready=0, expected 1");
         return;
      end
      bus.in_valid = 1'b1;
      bus.dividend = dd;
      bus.divisor  = dv;
      if (track) begin
         e.q   = eq;
         e.r   = er;
         e.dbz = edbz;
         e.lat = (dv == '0) ? 1 : W + 1;
         e.acc = cyc;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_ov = 1'b0;
         end else begin
            if (bus.out_valid && !prev_ov) begin
               if (sb.size() == 0) begin
                  checks++;
                  fails++;
                  have_cur = 1'b0;
                  $display("[TB] FAIL unexpected_result: out_valid=1 with quotient=0x%0h, expected no result",
                           bus.quotient);
               end else begin
                  cur = sb.pop_front();
                  have_cur = 1'b1;
                  checkOutput("quotient", 32'(bus.quotient), 32'(cur.q));
                  checkOutput("remainder", 32'(bus.remainder), 32'(cur.r));
                  checkOutput("div_by_zero", 32'(bus.div_by_zero), 32'(cur.dbz));
                  checkOutput("latency", 32'(cyc - cur.acc), 32'(cur.lat));
               end
            end else if (bus.out_valid && have_cur) begin
               checkOutput("held_quotient", 32'(bus.quotient), 32'(cur.q));
               checkOutput("held_remainder", 32'(bus.remainder), 32'(cur.r));
               checkOutput("held_div_by_zero", 32'(bus.div_by_zero), 32'(cur.dbz));
            end
            if (bus.out_valid)
               checkOutput("in_ready_in_done", 32'(bus.in_ready), 32'(0));
            prev_ov = bus.out_valid;
         end
      end
   end

   initial begin
      int n;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'(0));
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'(1));
      checkOutput("rst_busy", 32'(bus.busy), 32'(0));
      checkOutput("rst_quotient", 32'(bus.quotient), 32'(0));
      checkOutput("rst_remainder", 32'(bus.remainder), 32'(0));
      checkOutput("rst_div_by_zero", 32'(bus.div_by_zero), 32'(0));
      rst = 1'b0;

      applyStimulus(16'd55, 8'd10, RND ? 16'd6 : 16'd5, 8'd5, 1'b0, 1'b1);
      checkOutput("busy_in_run", 32'(bus.busy), 32'(1));
      checkOutput("in_ready_in_run", 32'(bus.in_ready), 32'(0));

      // Junk presented while busy must be neither accepted nor queued.
      applyStimulus(16'd52, 8'd8, RND ? 16'd7 : 16'd6, 8'd4, 1'b0, 1'b1);
      bus.in_valid = 1'b1;
      bus.dividend = 16'hAAAA;
      bus.divisor  = 8'd3;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;

      applyStimulus(16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 1'b1);
      applyStimulus(16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 1'b1);
      applyStimulus(16'd65534, 8'd255, RND ? 16'd257 : 16'd256, 8'd254, 1'b0, 1'b1);
      applyStimulus(16'd7, 8'd10, RND ? 16'd1 : 16'd0, 8'd7, 1'b0, 1'b1);
      applyStimulus(16'd0, 8'd5, 16'd0, 8'd0, 1'b0, 1'b1);

      n = 0;
      while (!(bus.in_ready && sb.size() == 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      bus.out_ready = 1'b0;
      applyStimulus(16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 1'b1);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("bp_out_valid_seen", 32'(bus.out_valid), 32'(1));
      repeat (5) begin
         @(negedge clk);
         checkOutput("bp_out_valid", 32'(bus.out_valid), 32'(1));
         checkOutput("bp_busy", 32'(bus.busy), 32'(1));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      checkOutput("drain_out_valid", 32'(bus.out_valid), 32'(0));
      checkOutput("drain_in_ready", 32'(bus.in_ready), 32'(1));
      checkOutput("drain_kept_quotient", 32'(bus.quotient), 32'(14));
      checkOutput("drain_kept_remainder", 32'(bus.remainder), 32'(2));

      // Abort a division partway through; no result may ever appear for it.
      applyStimulus(16'd1000, 8'd3, 16'd333, 8'd1, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort_out_valid", 32'(bus.out_valid), 32'(0));
      checkOutput("abort_busy", 32'(bus.busy), 32'(0));
      checkOutput("abort_quotient", 32'(bus.quotient), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_in_ready", 32'(bus.in_ready), 32'(1));

      applyStimulus(16'd9, 8'd3, 16'd3, 8'd0, 1'b0, 1'b1);
      n = 0;
      while (!(bus.in_ready && sb.size() == 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("scoreboard_drained", 32'(sb.size()), 32'(0));
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/csa_sum_divider.md
Name: csa_sum_divider

Overview:
- Sequential restoring divider on the consumer side of the 10-operand carry-save adder.
- Takes the 16-bit sum from that adder (z) and divides it by an operand count or other divisor, producing the mean as quotient/remainder.
- Sits after the CSA + final ripple adder; uses valid/ready handshakes on input and output.
- One quotient bit per clock.

Parameters:
- W, 16, dividend and quotient width (matches CSA sum width).
- DW, 8, divisor and remainder width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  dividend/divisor present.
- in_ready  output  1  block can accept; high only in IDLE.
- dividend  input  W  unsigned sum from the CSA.
- divisor  input  DW  unsigned divisor (10 for a 10-operand mean).
- out_valid  output  1  result registers valid.
- out_ready  input  1  downstream accepts result.
- quotient  output  W  unsigned quotient.
- remainder  output  DW  unsigned remainder.
- div_by_zero  output  1  divisor was 0 for this result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE. All of the following are 0: quotient, remainder, div_by_zero, out_valid, busy, and the internal counter. in_ready=1 once state is IDLE.
- States:
  - IDLE -> RUN on in_valid&in_ready when divisor!=0.
  - IDLE -> DONE when divisor==0.
  - RUN -> DONE after W iterations.
  - DONE -> IDLE on out_valid&out_ready.
- Accept cycle T: latch dividend into the shift register and divisor into the divisor register, clear the partial remainder (DW+1 bits) and the counter.
- RUN iteration, one per cycle:
  - Shift {rem, dividend_sr} left by 1.
  - trial = rem - {1'b0, divisor}.
  - If trial is non-negative: rem = trial, quotient LSB = 1; else restore, LSB = 0.
  - Iterations occupy cycles T+1..T+W; out_valid rises at T+W+1 (T+17 by default).
- Divide by zero: no RUN. At T+1: out_valid=1, quotient = all ones, remainder = dividend[DW-1:0], div_by_zero=1.
- DONE:
  - quotient, remainder and div_by_zero are held stable while out_valid=1 and out_ready=0 (backpressure of any length).
  - in_ready=0 throughout.
- Handshake at DONE:
  - On out_valid&out_ready, out_valid drops the next cycle and the state returns to IDLE.
  - in_ready rises that same next cycle. No same-cycle result-drain/new-accept overlap.
  - Result registers keep their last values after the drain; only out_valid clears.
- Inputs are ignored outside IDLE. in_valid asserted during RUN/DONE has no effect and is not queued.
- Width rules: all arithmetic is unsigned. remainder < divisor always holds for divisor != 0. quotient never overflows W bits.
- Reset mid-RUN or mid-DONE aborts immediately to the reset values. No partial result is presented.
- Back-to-back: the minimum spacing between accepts is W+2 cycles when out_ready is held at 1.

Optional Feature:
- Macro: CSA_DIV_ROUND_NEAREST_EN.
- Defined:
  - On the transition into DONE (divisor != 0), if 2*rem >= divisor, quotient is incremented by 1.
  - The increment saturates at all ones.
  - remainder still reports the truncated remainder.
  - The rounding add occurs in the same cycle as the last iteration, so latency is unchanged.
- Not defined: truncating division only. No rounding logic is synthesized.

Test Plan:
- dividend=55 (sum 1..10), divisor=10, out_ready=1 -> at T+17: quotient=5, remainder=5, div_by_zero=0. With CSA_DIV_ROUND_NEAREST_EN: quotient=6.
- dividend=52 (sum 3..10), divisor=8 -> quotient=6, remainder=4. Rounded: quotient=7 (2*4 >= 8).
- dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0. Rounded: no increment (rem=0), no overflow.
- dividend=0x1234, divisor=0 -> at T+1: out_valid=1, quotient=0xFFFF, remainder=0x34, div_by_zero=1.
- dividend=100, divisor=7, out_ready held 0 for 5 cycles after out_valid -> quotient=14, remainder=2 stable throughout, in_ready=0. out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Accept dividend=1000, divisor=3; assert rst at T+8 -> immediately out_valid=0, busy=0, quotient=0, in_ready=1 after release. New request 9/3 -> quotient=3, remainder=0 at T'+17.
